// File: rtl/ctrl_decode_stage_pkg.sv
// Shared constants and types for the RV32 decode stage.
//   - ALU operation codes (5-bit, M-extension ops live at 16..23)
//   - mcause codes for synchronous exceptions
//   - out_ctrl bundle layout (struct + bit offsets) and CTRL_W
//   - canonical NOP instruction word
package ctrl_decode_stage_pkg;

  localparam int CTRL_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;
  localparam logic [31:0] INSTR_MRET   = 32'h30200073;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  // PC4 must stay 0 so an all-zero bundle is a NOP
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [2:0] WSEL_ALU = 3'd0;
  localparam logic [2:0] WSEL_MEM = 3'd1;
  localparam logic [2:0] WSEL_PC4 = 3'd2;
  localparam logic [2:0] WSEL_IMM = 3'd3;
  localparam logic [2:0] WSEL_CSR = 3'd4;

  localparam int CTRL_MDU_EN        = 0;
  localparam int CTRL_CSR_WDATA_SEL = 1;
  localparam int CTRL_CSR_WDATA_OP  = 2;
  localparam int CTRL_IS_LOAD       = 4;
  localparam int CTRL_RF_WSEL       = 5;
  localparam int CTRL_RF_WE         = 8;
  localparam int CTRL_RD2_EN        = 9;
  localparam int CTRL_RD1_EN        = 10;
  localparam int CTRL_ALU_B_SEL     = 11;
  localparam int CTRL_ALU_A_SEL     = 12;
  localparam int CTRL_ALU_F_OP      = 13;
  localparam int CTRL_ALU_OP        = 16;
  localparam int CTRL_MEM_EXT_OP    = 21;
  localparam int CTRL_RAM_W_OP      = 24;
  localparam int CTRL_RAM_WE        = 26;
  localparam int CTRL_NPC_OP        = 27;
  localparam int CTRL_SEXT_OP       = 29;

  // Field order (MSB first) matches the CTRL_* offsets above.
  typedef struct packed {
    logic [2:0] sext_op;
    logic [1:0] npc_op;
    logic       ram_we;
    logic [1:0] ram_w_op;
    logic [2:0] mem_ext_op;
    logic [4:0] alu_op;
    logic [2:0] alu_f_op;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       rd1_en;
    logic       rd2_en;
    logic       rf_we;
    logic [2:0] rf_wsel;
    logic       is_load;
    logic [1:0] csr_wdata_op;
    logic       csr_wdata_sel;
    logic       mdu_en;
  } ctrl_t;

  // Integer ALU op from funct3; alt selects SUB/SRA (funct7 = 0100000).
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode_core.sv
// Combinational RV32 instruction decoder.
//   instr      in   32      instruction word
//   ctrl       out  CTRL_W  packed control bundle (ctrl_t layout)
//   exc        out  1       synchronous exception
//   exc_cause  out  4       mcause code when exc=1
//   mret       out  1       instruction is mret
module ctrl_decode_core
  import ctrl_decode_stage_pkg::*;
#(
  parameter bit ENABLE_M      = 1'b1,
  parameter bit ENABLE_SYS    = 1'b1,
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic              exc,
  output logic [3:0]        exc_cause,
  output logic              mret
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      c;
  logic       illegal;
  logic       is_ecall;
  logic       is_ebreak;
  logic       is_mret;
  logic       alt;
  logic       canon;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    c         = '0;
    illegal   = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    is_mret   = 1'b0;
    alt       = 1'b0;
    canon     = 1'b1;
    case (opcode)
      OPC_LUI: begin
        c.sext_op = SEXT_U;
        c.rf_we   = 1'b1;
        c.rf_wsel = WSEL_IMM;
      end
      OPC_AUIPC: begin
        c.sext_op   = SEXT_U;
        c.alu_a_sel = 1'b1;
        c.alu_b_sel = 1'b1;
        c.alu_op    = ALU_ADD;
        c.rf_we     = 1'b1;
      end
      OPC_JAL: begin
        c.sext_op = SEXT_J;
        c.npc_op  = NPC_JAL;
        c.rf_we   = 1'b1;
        c.rf_wsel = WSEL_PC4;
      end
      OPC_JALR: begin
        illegal   = (f3 != 3'b000);
        c.sext_op = SEXT_I;
        c.npc_op  = NPC_JALR;
        c.rd1_en  = 1'b1;
        c.rf_we   = 1'b1;
        c.rf_wsel = WSEL_PC4;
      end
      OPC_BRANCH: begin
        illegal    = (f3[2:1] == 2'b01);
        c.sext_op  = SEXT_B;
        c.npc_op   = NPC_BR;
        c.rd1_en   = 1'b1;
        c.rd2_en   = 1'b1;
        c.alu_op   = ALU_SUB;
        c.alu_f_op = f3;
      end
      OPC_LOAD: begin
        // legal widths: LB LH LW LBU LHU
        illegal      = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        c.sext_op    = SEXT_I;
        c.rd1_en     = 1'b1;
        c.alu_b_sel  = 1'b1;
        c.rf_we      = 1'b1;
        c.rf_wsel    = WSEL_MEM;
        c.is_load    = 1'b1;
        c.mem_ext_op = f3;
      end
      OPC_STORE: begin
        illegal     = f3[2] || (f3[1:0] == 2'b11);
        c.sext_op   = SEXT_S;
        c.rd1_en    = 1'b1;
        c.rd2_en    = 1'b1;
        c.alu_b_sel = 1'b1;
        c.ram_we    = 1'b1;
        c.ram_w_op  = f3[1:0];
      end
      OPC_OP_IMM: begin
        // only the shift forms carry a funct7; others treat [31:25] as immediate
        alt = (f3 == 3'b101) && (f7 == 7'b0100000);
        if (f3 == 3'b001)      canon = (f7 == 7'b0000000);
        else if (f3 == 3'b101) canon = (f7 == 7'b0000000) || alt;
        illegal     = STRICT_DECODE && !canon;
        c.sext_op   = SEXT_I;
        c.rd1_en    = 1'b1;
        c.alu_b_sel = 1'b1;
        c.rf_we     = 1'b1;
        c.alu_op    = alu_from_f3(f3, alt);
      end
      OPC_OP: begin
        c.rd1_en = 1'b1;
        c.rd2_en = 1'b1;
        c.rf_we  = 1'b1;
        if (f7 == 7'b0000001) begin
          illegal  = !ENABLE_M;
          c.mdu_en = 1'b1;
          c.alu_op = {2'b10, f3};
        end else begin
          alt      = (f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101));
          canon    = (f7 == 7'b0000000) || alt;
          illegal  = STRICT_DECODE && !canon;
          c.alu_op = alu_from_f3(f3, alt);
        end
      end
      OPC_FENCE: begin
        illegal = (f3[2:1] != 2'b00);
      end
      OPC_SYSTEM: begin
        if (!ENABLE_SYS) begin
          illegal = 1'b1;
        end else if (f3 == 3'b000) begin
          is_ecall  = (instr == INSTR_ECALL);
          is_ebreak = (instr == INSTR_EBREAK);
          is_mret   = (instr == INSTR_MRET);
          illegal   = !(is_ecall || is_ebreak || is_mret);
        end else if (f3 == 3'b100) begin
          illegal = 1'b1;
        end else begin
          // f3[2] selects the zimm forms, which do not read rs1
          c.rf_we         = 1'b1;
          c.rf_wsel       = WSEL_CSR;
          c.rd1_en        = !f3[2];
          c.csr_wdata_op  = f3[1:0];
          c.csr_wdata_sel = f3[2];
        end
      end
      default: illegal = 1'b1;
    endcase

    if (instr[1:0] != 2'b11) illegal = 1'b1;

    exc       = 1'b0;
    exc_cause = 4'd0;
    mret      = 1'b0;
    if (illegal) begin
      c         = '0;
      exc       = 1'b1;
      exc_cause = CAUSE_ILLEGAL;
    end else if (is_ecall) begin
      exc       = 1'b1;
      exc_cause = CAUSE_ECALL;
    end else if (is_ebreak) begin
      exc       = 1'b1;
      exc_cause = CAUSE_BREAK;
    end else if (is_mret) begin
      mret = 1'b1;
    end

    if (exc || mret) begin
      c.rf_we  = 1'b0;
      c.ram_we = 1'b0;
      c.mdu_en = 1'b0;
      c.npc_op = NPC_PC4;
    end
    ctrl = c;
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (main + skid).
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           IF/ID handshake (in_ready is a flop output)
//   in_instr, in_pc             incoming beat
//   flush                       drop every held beat and the beat on the input
//   out_valid/out_ready         EX handshake
//   out_instr, out_pc           passed-through beat
//   out_ctrl                    decoded control bundle
//   out_exc, out_exc_cause      synchronous exception and mcause code
//   out_mret                    beat is mret
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit ENABLE_M      = 1'b1,
  parameter bit ENABLE_SYS    = 1'b1,
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_exc,
  output logic [3:0]        out_exc_cause,
  output logic              out_mret
);

  localparam int BEAT_W = 32 + XLEN + CTRL_W + 1 + 4 + 1;
  localparam logic [BEAT_W-1:0] BEAT_RST = {NOP_INSTR, {(BEAT_W-32){1'b0}}};

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_exc;
  logic [3:0]        dec_cause;
  logic              dec_mret;
  logic [BEAT_W-1:0] beat_d;
  logic [BEAT_W-1:0] main_q;
  logic [BEAT_W-1:0] skid_q;
  logic              main_valid;
  logic              skid_valid;
  logic              accept;

  ctrl_decode_core #(
    .ENABLE_M      (ENABLE_M),
    .ENABLE_SYS    (ENABLE_SYS),
    .STRICT_DECODE (STRICT_DECODE)
  ) u_core (
    .instr     (in_instr),
    .ctrl      (dec_ctrl),
    .exc       (dec_exc),
    .exc_cause (dec_cause),
    .mret      (dec_mret)
  );

  assign beat_d   = {in_instr, in_pc, dec_ctrl, dec_exc, dec_cause, dec_mret};
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;

  // skid is only ever filled while main is full, so skid_valid implies
  // main_valid and in_ready=0 blocks an accept during the skid->main move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= BEAT_RST;
      skid_q     <= BEAT_RST;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || out_ready) begin
      main_valid <= accept;
      if (accept) main_q <= beat_d;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_q     <= beat_d;
    end
  end

  assign out_valid = main_valid;
  assign {out_instr, out_pc, out_ctrl, out_exc, out_exc_cause, out_mret} = main_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
module tb_ctrl_decode_stage;
  import ctrl_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic              a_in_ready, a_out_valid, a_exc, a_mret;
  logic [31:0]       a_instr, a_pc;
  logic [CTRL_W-1:0] a_ctrl;
  logic [3:0]        a_cause;
  logic              b_in_ready, b_out_valid, b_exc, b_mret;
  logic [31:0]       b_instr, b_pc;
  logic [CTRL_W-1:0] b_ctrl;
  logic [3:0]        b_cause;
  ctrl_t ca, cb;
  assign ca = a_ctrl;
  assign cb = b_ctrl;

  ctrl_decode_stage dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_instr(a_instr), .out_pc(a_pc), .out_ctrl(a_ctrl),
    .out_exc(a_exc), .out_exc_cause(a_cause), .out_mret(a_mret));

  ctrl_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_SYS(1'b0), .STRICT_DECODE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_instr(b_instr), .out_pc(b_pc), .out_ctrl(b_ctrl),
    .out_exc(b_exc), .out_exc_cause(b_cause), .out_mret(b_mret));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } beat_t;
  beat_t q[$];

  typedef struct packed {
    logic exc; logic [3:0] cause; logic mret;
    logic rf_we; logic ram_we; logic mdu_en; logic is_load;
    logic chk_alu; logic [4:0] alu;
  } exp_t;

  logic [6:0] ops [0:10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
  logic [6:0] f7s [0:2]  = '{7'h00, 7'h20, 7'h01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: classification rules written as per-opcode legality tables.
  function automatic exp_t ref_dec(input logic [31:0] i, input bit m, input bit sys, input bit strict);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit legal;
    bit sub_alt;
    e = '0; op = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; legal = 0;
    if (sys && i == 32'h00000073) begin e.exc = 1; e.cause = 4'd11; return e; end
    if (sys && i == 32'h00100073) begin e.exc = 1; e.cause = 4'd3;  return e; end
    if (sys && i == 32'h30200073) begin e.mret = 1; return e; end
    case (op)
      7'h37, 7'h17, 7'h6f: begin legal = 1; e.rf_we = 1; end
      7'h67: begin legal = (f3 == 0); e.rf_we = 1; end
      7'h63: legal = !(f3 == 2 || f3 == 3);
      7'h03: begin legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); e.rf_we = 1; e.is_load = 1; end
      7'h23: begin legal = (f3 <= 2); e.ram_we = 1; end
      7'h13: begin
        e.rf_we = 1;
        if (f3 == 1)      legal = !strict || f7 == 0;
        else if (f3 == 5) legal = !strict || f7 == 0 || f7 == 7'h20;
        else              legal = 1;
      end
      7'h33: begin
        e.rf_we = 1; e.chk_alu = 1;
        if (f7 == 7'h01) begin
          legal = m; e.mdu_en = 1;
          case (f3)
            0: e.alu = ALU_MUL;  1: e.alu = ALU_MULH; 2: e.alu = ALU_MULHSU; 3: e.alu = ALU_MULHU;
            4: e.alu = ALU_DIV;  5: e.alu = ALU_DIVU; 6: e.alu = ALU_REM;    default: e.alu = ALU_REMU;
          endcase
        end else begin
          sub_alt = (f7 == 7'h20) && (f3 == 0 || f3 == 5);
          legal = !strict || f7 == 0 || sub_alt;
          case (f3)
            0: e.alu = sub_alt ? ALU_SUB : ALU_ADD;  1: e.alu = ALU_SLL;
            2: e.alu = ALU_SLT;  3: e.alu = ALU_SLTU; 4: e.alu = ALU_XOR;
            5: e.alu = sub_alt ? ALU_SRA : ALU_SRL;  6: e.alu = ALU_OR;
            default: e.alu = ALU_AND;
          endcase
        end
      end
      7'h0f: legal = (f3 < 2);
      7'h73: begin legal = sys && f3 != 0 && f3 != 4; e.rf_we = 1; end
      default: legal = 0;
    endcase
    if (i[1:0] != 2'b11) legal = 0;
    if (!legal) begin e = '0; e.exc = 1; e.cause = 4'd2; end
    return e;
  endfunction

  task automatic chk_dut(input string n, input bit m, input bit sys, input bit strict,
                         input logic ov, input logic ir, input logic [31:0] instr, input logic [31:0] pc,
                         input ctrl_t c, input logic exc, input logic [3:0] cause, input logic mret);
    exp_t e;
    chk({n, "_out_valid"}, ov, q.size() > 0);
    chk({n, "_in_ready"}, ir, q.size() < 2);
    if (q.size() > 0) begin
      e = ref_dec(q[0].instr, m, sys, strict);
      chk({n, "_instr"}, instr, q[0].instr);
      chk({n, "_pc"}, pc, q[0].pc);
      chk({n, "_exc"}, exc, e.exc);
      chk({n, "_mret"}, mret, e.mret);
      chk({n, "_rf_we"}, c.rf_we, e.rf_we);
      chk({n, "_ram_we"}, c.ram_we, e.ram_we);
      chk({n, "_mdu_en"}, c.mdu_en, e.mdu_en);
      chk({n, "_is_load"}, c.is_load, e.is_load);
      if (e.exc) chk({n, "_cause"}, cause, e.cause);
      if (e.exc || e.mret) chk({n, "_npc_pc4"}, c.npc_op, NPC_PC4);
      if (e.chk_alu && !e.exc) chk({n, "_alu_op"}, c.alu_op, e.alu);
    end
  endtask

  task automatic check_all();
    chk_dut("a", 1, 1, 1, a_out_valid, a_in_ready, a_instr, a_pc, ca, a_exc, a_cause, a_mret);
    chk_dut("b", 0, 0, 0, b_out_valid, b_in_ready, b_instr, b_pc, cb, b_exc, b_cause, b_mret);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bit acc;
    in_valid = v; in_instr = instr; in_pc = pc; out_ready = rdy; flush = fl;
    acc = v && (q.size() < 2) && !fl;
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) q.push_back('{instr: instr, pc: pc});
    end
    check_all();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, a_out_valid, 1'b0);
    chk({tag, "_in_ready"}, a_in_ready, 1'b1);
    chk({tag, "_instr"}, a_instr, NOP_INSTR);
    chk({tag, "_pc"}, a_pc, 32'd0);
    chk({tag, "_ctrl"}, a_ctrl, 32'd0);
    chk({tag, "_exc"}, a_exc, 1'b0);
    chk({tag, "_cause"}, a_cause, 4'd0);
    chk({tag, "_mret"}, a_mret, 1'b0);
    chk({tag, "_b_out_valid"}, b_out_valid, 1'b0);
    chk({tag, "_b_ctrl"}, b_ctrl, 32'd0);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    int sel;
    k = $urandom_range(0, 15);
    w = $urandom;
    case (k)
      0: ;
      1: w = 32'h00000073;
      2: w = 32'h00100073;
      3: w = 32'h30200073;
      4: begin w[6:0] = 7'h73; w[14:12] = 3'b000; end
      default: begin
        w[6:0] = ops[$urandom_range(0, 10)];
        sel = $urandom_range(0, 3);
        if (sel < 3) w[31:25] = f7s[sel];
      end
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset_state("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // add x3,x1,x2
    cycle(1, 32'h002081B3, 32'h100, 1, 0);
    chk("add_alu_op", ca.alu_op, ALU_ADD);
    chk("add_rd1_en", ca.rd1_en, 1'b1);
    chk("add_rd2_en", ca.rd2_en, 1'b1);
    chk("add_rf_we", ca.rf_we, 1'b1);
    chk("add_exc", a_exc, 1'b0);
    // mul: M enabled vs disabled
    cycle(1, 32'h022081B3, 32'h104, 1, 0);
    chk("mul_alu_op", ca.alu_op, ALU_MUL);
    chk("mul_mdu_en", ca.mdu_en, 1'b1);
    chk("mul_nom_exc", b_exc, 1'b1);
    chk("mul_nom_cause", b_cause, 4'd2);
    chk("mul_nom_rf_we", cb.rf_we, 1'b0);
    cycle(1, 32'h00000073, 32'h108, 1, 0);
    chk("ecall_cause", a_cause, 4'd11);
    cycle(1, 32'h00100073, 32'h10c, 1, 0);
    chk("ebreak_cause", a_cause, 4'd3);
    cycle(1, 32'h30200073, 32'h110, 1, 0);
    chk("mret_flag", a_mret, 1'b1);
    chk("mret_exc", a_exc, 1'b0);
    cycle(1, 32'h00000000, 32'h114, 1, 0);
    chk("zero_cause", a_cause, 4'd2);
    chk("zero_rf_we", ca.rf_we, 1'b0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // back-pressure: third beat refused, order preserved
    cycle(1, 32'h00100093, 32'h200, 0, 0);
    cycle(1, 32'h00200113, 32'h204, 0, 0);
    chk("bp_in_ready_low", a_in_ready, 1'b0);
    cycle(1, 32'h00300193, 32'h208, 0, 0);
    chk("bp_hold_first", a_pc, 32'h200);
    cycle(1, 32'h00300193, 32'h208, 1, 0);
    chk("bp_second_out", a_pc, 32'h204);
    chk("bp_in_ready_back", a_in_ready, 1'b1);
    cycle(1, 32'h00300193, 32'h208, 1, 0);
    chk("bp_third_out", a_pc, 32'h208);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // flush with both slots full and a beat on the input
    cycle(1, 32'h00400213, 32'h300, 0, 0);
    cycle(1, 32'h00500293, 32'h304, 0, 0);
    cycle(1, 32'h00600313, 32'h308, 1, 1);
    chk("flush_out_valid", a_out_valid, 1'b0);
    chk("flush_in_ready", a_in_ready, 1'b1);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 3) != 0, gen_instr(), {$urandom_range(0, 32'hFFFF), 2'b00},
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    // async reset while a beat is held
    cycle(1, 32'h002081B3, 32'h400, 0, 0);
    chk("pre_rst_valid", a_out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_reset_state("async_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 32'h40208133, 32'h500, 1, 0);
    chk("post_rst_sub", ca.alu_op, ALU_SUB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
